// File: rtl/nibble_parity_pkg.sv
// Shared definitions for the nibble parity checker: FSM state encoding and parity-mode constants.
package nibble_parity_pkg;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    WAIT_PAR = 2'd1,
    REPORT   = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : nibble_parity_pkg

// File: rtl/XOR4_gate_v.sv
// 4-input XOR primitive: folds four bits into a single parity bit.
module XOR4_gate_v (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_y
);

  assign o_y = i_a ^ i_b ^ i_c ^ i_d;

endmodule : XOR4_gate_v

// File: rtl/nibble_parity_checker_v.sv
// Frame-level parity checker: folds a valid/ready nibble stream per frame, compares the result
// with a received parity bit and keeps a saturating count of mismatched frames.
module nibble_parity_checker_v
  import nibble_parity_pkg::*;
#(
  parameter int unsigned FRAME_NIBBLES = 4,
  parameter bit          PARITY_ODD    = PAR_EVEN,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [3:0]           i_nibble,
  output logic                 o_ready,
  input  logic                 i_par_valid,
  input  logic                 i_par,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_parity,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int unsigned          CNT_W    = $clog2(FRAME_NIBBLES + 1);
  localparam logic [CNT_W-1:0]     LAST_NIB = CNT_W'(FRAME_NIBBLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_acc;
  logic                   w_acc_nxt;
  logic [CNT_W-1:0]       r_nib_cnt;
  logic [CNT_W-1:0]       w_nib_cnt_nxt;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_err;
  logic                   w_err_nxt;
  logic                   r_parity;
  logic                   w_parity_nxt;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [ERR_CNT_W-1:0]   w_err_cnt_nxt;
  logic                   w_fold;
  logic                   w_calc;
  logic                   w_mismatch;

  XOR4_gate_v u_fold (
    .i_a (i_nibble[0]),
    .i_b (i_nibble[1]),
    .i_c (i_nibble[2]),
    .i_d (i_nibble[3]),
    .o_y (w_fold)
  );

  assign w_calc     = r_acc ^ PARITY_ODD;
  assign w_mismatch = (w_calc != i_par);

  // Next-state and datapath updates; each state only looks at the input relevant to it.
  always_comb begin
    w_next_state  = r_state;
    w_acc_nxt     = r_acc;
    w_nib_cnt_nxt = r_nib_cnt;
    w_err_nxt     = r_err;
    w_parity_nxt  = r_parity;
    w_err_cnt_nxt = r_err_cnt;

    case (r_state)
      ACCUM: begin
        if (i_valid) begin
          w_acc_nxt = r_acc ^ w_fold;
          if (r_nib_cnt == LAST_NIB) begin
            w_nib_cnt_nxt = '0;
            w_next_state  = WAIT_PAR;
          end else begin
            w_nib_cnt_nxt = r_nib_cnt + 1'b1;
          end
        end
      end

      WAIT_PAR: begin
        if (i_par_valid) begin
          w_parity_nxt = w_calc;
          w_err_nxt    = w_mismatch;
          if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
          end
          w_next_state = REPORT;
        end
      end

      REPORT: begin
        w_acc_nxt    = 1'b0;
        w_next_state = ACCUM;
      end

      default: begin
        w_acc_nxt     = 1'b0;
        w_nib_cnt_nxt = '0;
        w_next_state  = ACCUM;
      end
    endcase
  end

  // ready/done are registered decodes of the upcoming state, so they track the state exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ACCUM;
      r_acc     <= 1'b0;
      r_nib_cnt <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_parity  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_acc     <= w_acc_nxt;
      r_nib_cnt <= w_nib_cnt_nxt;
      r_ready   <= (w_next_state == ACCUM);
      r_done    <= (w_next_state == REPORT);
      r_err     <= w_err_nxt;
      r_parity  <= w_parity_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign o_ready   = r_ready;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_parity  = r_parity;
  assign o_err_cnt = r_err_cnt;

endmodule : nibble_parity_checker_v

// File: tb/tb_nibble_parity_checker_v.sv
// Self-checking bench: an even-parity and an odd-parity checker share one stimulus stream and are
// compared against a frame-level parity model plus a table of hand-computed results.
`timescale 1ns/1ps
module tb_nibble_parity_checker_v;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [3:0] i_nibble;
  logic       i_par_valid;
  logic       i_par;

  logic       o_ready_e, o_done_e, o_err_e, o_parity_e;
  logic [7:0] o_err_cnt_e;
  logic       o_ready_o, o_done_o, o_err_o, o_parity_o;
  logic [7:0] o_err_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [3:0] frame_q[$];
  int         cnt_e_m = 0;
  int         cnt_o_m = 0;

  always #5 i_clk = ~i_clk;

  nibble_parity_checker_v #(.FRAME_NIBBLES(4), .PARITY_ODD(1'b0), .ERR_CNT_W(8)) dut_e (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_nibble(i_nibble), .o_ready(o_ready_e),
    .i_par_valid(i_par_valid), .i_par(i_par), .o_done(o_done_e), .o_err(o_err_e),
    .o_parity(o_parity_e), .o_err_cnt(o_err_cnt_e)
  );

  nibble_parity_checker_v #(.FRAME_NIBBLES(4), .PARITY_ODD(1'b1), .ERR_CNT_W(8)) dut_o (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_nibble(i_nibble), .o_ready(o_ready_o),
    .i_par_valid(i_par_valid), .i_par(i_par), .o_done(o_done_o), .o_err(o_err_o),
    .o_parity(o_parity_o), .o_err_cnt(o_err_cnt_o)
  );

  typedef struct {
    logic [15:0] nibs;      // first nibble in [15:12]
    logic        par;
    int          gap;
    bit          spur;
    logic        exp_par_e;
    logic        exp_err_e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one nibble after 'gap' idle cycles; spurious parity pulses optional during gaps/accept.
  task automatic put_nibble(input logic [3:0] n, input int gap, input bit spur);
    bit acc = 1'b0;
    int t = 0;
    i_valid = 1'b0;
    repeat (gap) begin
      i_par_valid = spur;
      i_par       = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid     = 1'b1;
    i_nibble    = n;
    i_par_valid = spur;
    while (!acc && t < 20) begin
      acc = o_ready_e;
      @(posedge i_clk); #1;
      t++;
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    i_valid     = 1'b0;
    i_par_valid = 1'b0;
    frame_q.push_back(n);
  endtask

  // Deliver the parity bit and check the report against the frame model.
  task automatic end_frame(input logic par);
    int   ones = 0;
    logic pe, po;
    foreach (frame_q[k]) ones += $countones(frame_q[k]);
    frame_q.delete();
    pe = 1'(ones % 2);
    po = ~pe;
    if (pe != par && cnt_e_m < 255) cnt_e_m++;
    if (po != par && cnt_o_m < 255) cnt_o_m++;
    chk("ready_drop", 32'(o_ready_e), 32'd0);
    chk("done_pre", 32'(o_done_e), 32'd0);
    i_par_valid = 1'b1;
    i_par       = par;
    @(posedge i_clk); #1;
    i_par_valid = 1'b0;
    chk("done_e", 32'(o_done_e), 32'd1);
    chk("done_o", 32'(o_done_o), 32'd1);
    chk("ready_report", 32'(o_ready_e), 32'd0);
    chk("parity_e", 32'(o_parity_e), 32'(pe));
    chk("err_e", 32'(o_err_e), 32'(pe != par));
    chk("cnt_e", 32'(o_err_cnt_e), 32'(cnt_e_m));
    chk("parity_o", 32'(o_parity_o), 32'(po));
    chk("err_o", 32'(o_err_o), 32'(po != par));
    chk("cnt_o", 32'(o_err_cnt_o), 32'(cnt_o_m));
    @(posedge i_clk); #1;
    chk("done_post", 32'(o_done_e), 32'd0);
    chk("ready_back", 32'(o_ready_e), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(o_ready_e), 32'd1);
    chk({tag, "_done"}, 32'(o_done_e), 32'd0);
    chk({tag, "_err"}, 32'(o_err_e), 32'd0);
    chk({tag, "_parity"}, 32'(o_parity_e), 32'd0);
    chk({tag, "_cnt"}, 32'(o_err_cnt_e), 32'd0);
    chk({tag, "_cnt_o"}, 32'(o_err_cnt_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{16'h1248, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFF1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{16'h3333, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h1248, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'hA501, 1'b1, 1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'hE000, 1'b0, 2, 1'b0, 1'b1, 1'b1};

    i_rst = 1'b1; i_valid = 1'b0; i_nibble = '0; i_par_valid = 1'b0; i_par = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_state("rst0");
    i_rst = 1'b0;

    foreach (tbl[v]) begin
      for (int k = 0; k < 4; k++) begin
        logic [15:0] w;
        w = tbl[v].nibs << (4 * k);
        put_nibble(w[15:12], tbl[v].gap, tbl[v].spur);
      end
      end_frame(tbl[v].par);
      chk($sformatf("tbl%0d_par", v), 32'(o_parity_e), 32'(tbl[v].exp_par_e));
      chk($sformatf("tbl%0d_err", v), 32'(o_err_e), 32'(tbl[v].exp_err_e));
    end

    // Nibble 7 held through WAIT_PAR/REPORT must become nibble 1 of the next frame.
    put_nibble(4'h1, 0, 1'b0);
    put_nibble(4'h2, 0, 1'b0);
    put_nibble(4'h4, 0, 1'b0);
    put_nibble(4'h8, 0, 1'b0);
    i_valid = 1'b1; i_nibble = 4'h7;
    end_frame(1'b0);
    put_nibble(4'h7, 0, 1'b0);
    put_nibble(4'h0, 0, 1'b0);
    put_nibble(4'h0, 0, 1'b0);
    put_nibble(4'h0, 0, 1'b0);
    end_frame(1'b1);
    chk("hold7_err", 32'(o_err_e), 32'd0);

    // Randomized frames against the model.
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < 4; k++)
        put_nibble(4'($urandom_range(15)), int'($urandom_range(2)), 1'($urandom_range(1)));
      end_frame(1'($urandom_range(1)));
    end

    // Reset mid-frame discards the partial frame.
    put_nibble(4'hF, 0, 1'b0);
    put_nibble(4'h1, 0, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    frame_q.delete();
    cnt_e_m = 0;
    cnt_o_m = 0;
    check_reset_state("rst1");
    put_nibble(4'h1, 0, 1'b0);
    put_nibble(4'h2, 0, 1'b0);
    put_nibble(4'h4, 0, 1'b0);
    put_nibble(4'h8, 0, 1'b0);
    end_frame(1'b0);
    chk("post_rst_err", 32'(o_err_e), 32'd0);

    // Saturation of the error counter.
    for (int f = 0; f < 260; f++) begin
      put_nibble(4'hF, 0, 1'b0);
      put_nibble(4'hF, 0, 1'b0);
      put_nibble(4'hF, 0, 1'b0);
      put_nibble(4'h1, 0, 1'b0);
      end_frame(1'b0);
    end
    chk("sat_cnt", 32'(o_err_cnt_e), 32'd255);

    // Odd parity: all-zero frame with received 1 is a match.
    for (int k = 0; k < 4; k++) put_nibble(4'h0, 0, 1'b0);
    end_frame(1'b1);
    chk("odd_err", 32'(o_err_o), 32'd0);
    chk("odd_par", 32'(o_parity_o), 32'd1);
    chk("sat_hold", 32'(o_err_cnt_e), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nibble_parity_checker_v
